// File: rtl/core_inst_queue.sv
// core_inst_queue: in-order instruction queue between decode and issue.
// Ports: clk, rst (sync, active-high), flush_i; write_valid_i/write_data_i
// (sparse slots, compacted in port order), write_ready_o; read_valid_o/
// read_data_o (oldest-first, fall-through), read_num_i (pop count);
// count_o, almost_full_o.
module core_inst_queue #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 8,
    parameter int WRITE_PORT   = 2,
    parameter int READ_PORT    = 2,
    parameter int AFULL_THRESH = DEPTH - WRITE_PORT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush_i,
    input  logic [WRITE_PORT-1:0]            write_valid_i,
    input  logic [WRITE_PORT*DATA_WIDTH-1:0] write_data_i,
    output logic                             write_ready_o,
    output logic [READ_PORT-1:0]             read_valid_o,
    output logic [READ_PORT*DATA_WIDTH-1:0]  read_data_o,
    input  logic [$clog2(READ_PORT+1)-1:0]   read_num_i,
    output logic [$clog2(DEPTH+1)-1:0]       count_o,
    output logic                             almost_full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] WR_LIMIT = CW'(DEPTH - WRITE_PORT);
    localparam logic [CW-1:0] AF_LIMIT = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] RD_MAX   = CW'(READ_PORT);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;

    logic [PW-1:0] woff [WRITE_PORT];
    logic [CW-1:0] wnum;
    logic [CW-1:0] wnum_acc;
    logic [CW-1:0] rreq;
    logic [CW-1:0] rnum;
    logic          wfire;

    assign write_ready_o = (count_q <= WR_LIMIT);
    assign almost_full_o = (count_q >= AF_LIMIT);
    assign count_o       = count_q;

    // Compaction: each valid slot lands at tail plus the number of
    // valid slots below it.
    always_comb begin
        wnum = '0;
        for (int k = 0; k < WRITE_PORT; k++) begin
            woff[k] = wnum[PW-1:0];
            wnum    = wnum + CW'(write_valid_i[k]);
        end
    end

    assign wfire    = write_ready_o && (|write_valid_i) && !flush_i;
    assign wnum_acc = wfire ? wnum : '0;

    // Clamp pops to what is both visible and present.
    always_comb begin
        rreq = CW'(read_num_i);
        if (rreq > RD_MAX) begin
            rreq = RD_MAX;
        end
        rnum = (rreq > count_q) ? count_q : rreq;
    end

    assign head_d  = head_q + PW'(rnum);
    assign tail_d  = tail_q + PW'(wnum_acc);
    assign count_d = count_q + wnum_acc - rnum;

    for (genvar i = 0; i < READ_PORT; i++) begin : g_rd
        assign read_valid_o[i] = (count_q > CW'(i));
        assign read_data_o[i*DATA_WIDTH +: DATA_WIDTH] =
            mem_q[head_q + PW'(i)];
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately not reset; pointers gate visibility.
    always_ff @(posedge clk) begin
        if (!rst && wfire) begin
            for (int k = 0; k < WRITE_PORT; k++) begin
                if (write_valid_i[k]) begin
                    mem_q[tail_q + woff[k]] <=
                        write_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_core_inst_queue.sv
// tb_core_inst_queue: scoreboard bench for core_inst_queue
// (DEPTH=8, two write and two read slots).
module tb_core_inst_queue;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic [1:0]  write_valid_i;
    logic [63:0] write_data_i;
    logic        write_ready_o;
    logic [1:0]  read_valid_o;
    logic [63:0] read_data_o;
    logic [1:0]  read_num_i;
    logic [3:0]  count_o;
    logic        almost_full_o;

    int n_chk;
    int n_err;

    logic [31:0] sb [$];
    bit          seq_mode;
    logic [31:0] exp_pop;

    core_inst_queue #(
        .DATA_WIDTH(32), .DEPTH(8), .WRITE_PORT(2), .READ_PORT(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .write_valid_i (write_valid_i),
        .write_data_i  (write_data_i),
        .write_ready_o (write_ready_o),
        .read_valid_o  (read_valid_o),
        .read_data_o   (read_data_o),
        .read_num_i    (read_num_i),
        .count_o       (count_o),
        .almost_full_o (almost_full_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rd(input int i);
        return read_data_o[i*32 +: 32];
    endfunction

    task automatic check_state();
        int n;
        n = sb.size();
        chk("count", 32'(count_o), 32'(n));
        chk("rvalid", 32'(read_valid_o), {30'b0, n > 1, n > 0});
        chk("wready", 32'(write_ready_o), 32'(n <= 6));
        chk("afull", 32'(almost_full_o), 32'(n >= 6));
        for (int i = 0; i < 2; i++) begin
            if (i < n) chk("rdata", rd(i), sb[i]);
        end
    endtask

    // Present one cycle of stimulus, predict, then step past the edge.
    task automatic drive(input logic [1:0] wv, input logic [31:0] d0,
                         input logic [31:0] d1, input logic [1:0] rn,
                         input logic fl, output int acc);
        int  rnum;
        bit  ready;
        check_state();
        write_valid_i = wv;
        write_data_i  = {d1, d0};
        read_num_i    = rn;
        flush_i       = fl;
        rnum  = (int'(rn) < sb.size()) ? int'(rn) : sb.size();
        ready = (8 - sb.size()) >= 2;
        acc   = 0;
        if (fl) begin
            sb.delete();
        end else begin
            for (int i = 0; i < rnum; i++) begin
                chk("pop", rd(i), sb[i]);
                if (seq_mode) begin
                    chk("order", rd(i), exp_pop);
                    exp_pop++;
                end
            end
            repeat (rnum) void'(sb.pop_front());
            if (ready) begin
                if (wv[0]) begin sb.push_back(d0); acc++; end
                if (wv[1]) begin sb.push_back(d1); acc++; end
            end
        end
        @(posedge clk);
        #1;
        write_valid_i = '0;
        read_num_i    = '0;
        flush_i       = 1'b0;
    endtask

    initial begin
        int          acc;
        logic [1:0]  wv;
        logic [1:0]  rn;
        logic [31:0] seq;
        n_chk = 0;
        n_err = 0;
        seq_mode = 1'b0;
        exp_pop = '0;
        rst = 1'b1;
        flush_i = 1'b0;
        write_valid_i = '0;
        write_data_i = '0;
        read_num_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_rvalid", 32'(read_valid_o), 32'd0);
        chk("rst_wready", 32'(write_ready_o), 32'd1);
        chk("rst_afull", 32'(almost_full_o), 32'd0);

        drive(2'b10, 32'h0, 32'hB, 2'd0, 1'b0, acc);
        chk("sparse_rv", 32'(read_valid_o), 32'd1);
        chk("sparse_d", rd(0), 32'hB);
        chk("sparse_cnt", 32'(count_o), 32'd1);
        drive(2'b00, 32'h0, 32'h0, 2'd1, 1'b0, acc);

        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 32'h100 + 32'(2*i), 32'h101 + 32'(2*i),
                  2'd0, 1'b0, acc);
        end
        chk("fill_cnt", 32'(count_o), 32'd8);
        chk("fill_wready", 32'(write_ready_o), 32'd0);
        chk("fill_afull", 32'(almost_full_o), 32'd1);
        drive(2'b11, 32'hDEAD, 32'hBEEF, 2'd0, 1'b0, acc);
        chk("fill5_cnt", 32'(count_o), 32'd8);
        chk("fill5_head", rd(0), 32'h100);

        drive(2'b00, 32'h0, 32'h0, 2'd1, 1'b0, acc);
        chk("nf_cnt7", 32'(count_o), 32'd7);
        chk("nf_wready", 32'(write_ready_o), 32'd0);
        drive(2'b11, 32'hAAAA, 32'hBBBB, 2'd2, 1'b0, acc);
        chk("nf_cnt", 32'(count_o), 32'd5);

        drive(2'b00, 32'h0, 32'h0, 2'd1, 1'b0, acc);
        chk("fl_cnt4", 32'(count_o), 32'd4);
        drive(2'b11, 32'hCCCC, 32'hDDDD, 2'd1, 1'b1, acc);
        chk("fl_cnt", 32'(count_o), 32'd0);
        chk("fl_rvalid", 32'(read_valid_o), 32'd0);
        chk("fl_wready", 32'(write_ready_o), 32'd1);
        drive(2'b01, 32'h55, 32'h0, 2'd0, 1'b0, acc);
        chk("fl_after", rd(0), 32'h55);

        chk("cl_cnt1", 32'(count_o), 32'd1);
        drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, acc);
        chk("cl_cnt", 32'(count_o), 32'd0);
        drive(2'b01, 32'h77, 32'h0, 2'd0, 1'b0, acc);
        chk("cl_data", rd(0), 32'h77);
        chk("cl_cnt_w", 32'(count_o), 32'd1);
        drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, acc);

        seq = 32'd1000;
        exp_pop = 32'd1000;
        seq_mode = 1'b1;
        for (int c = 0; c < 200; c++) begin
            wv = 2'($urandom_range(0, 3));
            rn = 2'($urandom_range(0, 2));
            drive(wv, seq, seq + 32'(wv[0]), rn, 1'b0, acc);
            seq = seq + 32'(acc);
        end
        for (int c = 0; c < 6; c++) begin
            drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, acc);
        end
        check_state();
        chk("wrap_cnt", 32'(count_o), 32'd0);
        chk("wrap_all", exp_pop, seq);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
